// File: rtl/exec_pipe_stager.sv
// Even/odd 7-deep result staging pipes feeding the forwarding bus and register-file write-back.
// Handles stall, branch flush, issue-time latency screening and same-register write conflicts.
module exec_pipe_stager #(
   parameter int FLUSH_DEPTH = 3,
   parameter int NUM_STAGES  = 7
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         flush,
   input  logic         even_issue_valid,
   input  logic [0:127] even_result,
   input  logic [0:2]   even_unit_id,
   input  logic [0:6]   even_reg_dst,
   input  logic [0:3]   even_latency,
   input  logic         even_reg_wr,
   input  logic         odd_issue_valid,
   input  logic [0:127] odd_result,
   input  logic [0:2]   odd_unit_id,
   input  logic [0:6]   odd_reg_dst,
   input  logic [0:3]   odd_latency,
   input  logic         odd_reg_wr,
   output logic [0:142] packed_1stage_even,
   output logic [0:142] packed_2stage_even,
   output logic [0:142] packed_3stage_even,
   output logic [0:142] packed_4stage_even,
   output logic [0:142] packed_5stage_even,
   output logic [0:142] packed_6stage_even,
   output logic [0:142] packed_7stage_even,
   output logic [0:142] packed_1stage_odd,
   output logic [0:142] packed_2stage_odd,
   output logic [0:142] packed_3stage_odd,
   output logic [0:142] packed_4stage_odd,
   output logic [0:142] packed_5stage_odd,
   output logic [0:142] packed_6stage_odd,
   output logic [0:142] packed_7stage_odd,
   output logic         wb_en_even,
   output logic [0:6]   wb_addr_even,
   output logic [0:127] wb_data_even,
   output logic         wb_en_odd,
   output logic [0:6]   wb_addr_odd,
   output logic [0:127] wb_data_odd,
   output logic         wb_conflict,
   output logic         latency_error
);

   typedef logic [0:142] stage_t;
   localparam stage_t BUBBLE = {143{1'b0}};

   stage_t even_q [1:NUM_STAGES];
   stage_t even_d [1:NUM_STAGES];
   stage_t odd_q  [1:NUM_STAGES];
   stage_t odd_d  [1:NUM_STAGES];
   stage_t even_iss_s;
   stage_t odd_iss_s;
   logic   wb_done_q;
   logic   wb_done_d;
   logic   lat_err_q;
   logic   lat_err_d;
   logic   wb_raw_even_s;
   logic   wb_raw_odd_s;
   logic   same_dst_s;

   function automatic logic lat_illegal(input logic [0:3] lat);
      return (lat == 4'd0) || (lat > 4'd7);
   endfunction

   // A screened entry keeps every field except its write enable.
   function automatic stage_t pack_issue(input logic valid, input logic [0:127] res,
                                         input logic [0:2] uid, input logic [0:6] dst,
                                         input logic [0:3] lat, input logic wr);
      stage_t r;
      if (valid) begin
         r = {res, uid, dst, lat, wr & ~lat_illegal(lat)};
      end else begin
         r = BUBBLE;
      end
      return r;
   endfunction

   function automatic stage_t next_stage(input int k, input stage_t cur, input stage_t prev,
                                         input logic stl, input logic fl);
      stage_t r;
      if (stl) begin
         r = cur;
      end else if (fl) begin
         r = prev;
      end else begin
         r = prev;
      end
      if (fl && (k <= FLUSH_DEPTH)) begin
         r[142] = 1'b0;
      end else begin
         r[142] = r[142];
      end
      return r;
   endfunction

   // Next-state of both staging pipes plus the sticky and hold flags.
   always_comb begin
      even_iss_s = pack_issue(even_issue_valid, even_result, even_unit_id, even_reg_dst,
                              even_latency, even_reg_wr);
      odd_iss_s  = pack_issue(odd_issue_valid, odd_result, odd_unit_id, odd_reg_dst,
                              odd_latency, odd_reg_wr);
      even_d[1]  = next_stage(1, even_q[1], flush ? BUBBLE : even_iss_s, stall, flush);
      odd_d[1]   = next_stage(1, odd_q[1], flush ? BUBBLE : odd_iss_s, stall, flush);
      for (int k = 2; k <= NUM_STAGES; k++) begin
         even_d[k] = next_stage(k, even_q[k], even_q[k-1], stall, flush);
         odd_d[k]  = next_stage(k, odd_q[k], odd_q[k-1], stall, flush);
      end
      wb_done_d = stall;
      if (!stall && !flush) begin
         lat_err_d = lat_err_q
                   | (even_issue_valid & even_reg_wr & lat_illegal(even_latency))
                   | (odd_issue_valid & odd_reg_wr & lat_illegal(odd_latency));
      end else begin
         lat_err_d = lat_err_q;
      end
   end

   // Stage registers, write-back hold flag and sticky latency error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 1; k <= NUM_STAGES; k++) begin
            even_q[k] <= BUBBLE;
            odd_q[k]  <= BUBBLE;
         end
         wb_done_q <= 1'b0;
         lat_err_q <= 1'b0;
      end else begin
         even_q    <= even_d;
         odd_q     <= odd_d;
         wb_done_q <= wb_done_d;
         lat_err_q <= lat_err_d;
      end
   end

   // Write-back straight from stage 7; odd wins a same-register collision.
   always_comb begin
      wb_raw_even_s = even_q[7][142] & ~wb_done_q;
      wb_raw_odd_s  = odd_q[7][142] & ~wb_done_q;
      same_dst_s    = (even_q[7][131:137] == odd_q[7][131:137]);
      wb_conflict   = wb_raw_even_s & wb_raw_odd_s & same_dst_s;
      wb_en_even    = wb_raw_even_s & ~wb_conflict;
      wb_en_odd     = wb_raw_odd_s;
      wb_addr_even  = even_q[7][131:137];
      wb_addr_odd   = odd_q[7][131:137];
      wb_data_even  = even_q[7][0:127];
      wb_data_odd   = odd_q[7][0:127];
   end

   assign latency_error      = lat_err_q;
   assign packed_1stage_even = even_q[1];
   assign packed_2stage_even = even_q[2];
   assign packed_3stage_even = even_q[3];
   assign packed_4stage_even = even_q[4];
   assign packed_5stage_even = even_q[5];
   assign packed_6stage_even = even_q[6];
   assign packed_7stage_even = even_q[7];
   assign packed_1stage_odd  = odd_q[1];
   assign packed_2stage_odd  = odd_q[2];
   assign packed_3stage_odd  = odd_q[3];
   assign packed_4stage_odd  = odd_q[4];
   assign packed_5stage_odd  = odd_q[5];
   assign packed_6stage_odd  = odd_q[6];
   assign packed_7stage_odd  = odd_q[7];

endmodule

// File: tb/tb_exec_pipe_stager.sv
// Randomized scoreboard bench for exec_pipe_stager against a queue-based pipeline model.
module tb_exec_pipe_stager;

   localparam int FD = 3;

   typedef struct packed {
      logic [127:0] res;
      logic [2:0]   uid;
      logic [6:0]   dst;
      logic [3:0]   lat;
      logic         wr;
      logic         written;
   } ent_t;

   typedef struct packed {
      logic         v;
      logic [127:0] res;
      logic [2:0]   uid;
      logic [6:0]   dst;
      logic [3:0]   lat;
      logic         wr;
   } iss_t;

   typedef struct packed {
      logic         ee;
      logic         eo;
      logic         cf;
      logic [6:0]   ae;
      logic [6:0]   ao;
      logic [127:0] de;
      logic [127:0] dob;
   } exp_t;

   logic clk = 1'b0;
   logic reset, stall, flush;
   logic ev_v, ev_wr, od_v, od_wr;
   logic [0:127] ev_res, od_res;
   logic [0:2] ev_uid, od_uid;
   logic [0:6] ev_dst, od_dst;
   logic [0:3] ev_lat, od_lat;
   logic [0:142] p1e, p2e, p3e, p4e, p5e, p6e, p7e, p1o, p2o, p3o, p4o, p5o, p6o, p7o;
   logic wb_en_even, wb_en_odd, wb_conflict, latency_error;
   logic [0:6] wb_addr_even, wb_addr_odd;
   logic [0:127] wb_data_even, wb_data_odd;
   logic [0:142] dut_e [7];
   logic [0:142] dut_o [7];

   int checks = 0;
   int failures = 0;
   ent_t me[$];
   ent_t mo[$];
   bit m_err;
   exp_t exp_q[$];
   iss_t idle;

   always #5 clk = ~clk;

   exec_pipe_stager #(.FLUSH_DEPTH(FD), .NUM_STAGES(7)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .even_issue_valid(ev_v), .even_result(ev_res), .even_unit_id(ev_uid),
      .even_reg_dst(ev_dst), .even_latency(ev_lat), .even_reg_wr(ev_wr),
      .odd_issue_valid(od_v), .odd_result(od_res), .odd_unit_id(od_uid),
      .odd_reg_dst(od_dst), .odd_latency(od_lat), .odd_reg_wr(od_wr),
      .packed_1stage_even(p1e), .packed_2stage_even(p2e), .packed_3stage_even(p3e),
      .packed_4stage_even(p4e), .packed_5stage_even(p5e), .packed_6stage_even(p6e),
      .packed_7stage_even(p7e),
      .packed_1stage_odd(p1o), .packed_2stage_odd(p2o), .packed_3stage_odd(p3o),
      .packed_4stage_odd(p4o), .packed_5stage_odd(p5o), .packed_6stage_odd(p6o),
      .packed_7stage_odd(p7o),
      .wb_en_even(wb_en_even), .wb_addr_even(wb_addr_even), .wb_data_even(wb_data_even),
      .wb_en_odd(wb_en_odd), .wb_addr_odd(wb_addr_odd), .wb_data_odd(wb_data_odd),
      .wb_conflict(wb_conflict), .latency_error(latency_error)
   );

   assign dut_e[0] = p1e; assign dut_e[1] = p2e; assign dut_e[2] = p3e; assign dut_e[3] = p4e;
   assign dut_e[4] = p5e; assign dut_e[5] = p6e; assign dut_e[6] = p7e;
   assign dut_o[0] = p1o; assign dut_o[1] = p2o; assign dut_o[2] = p3o; assign dut_o[3] = p4o;
   assign dut_o[4] = p5o; assign dut_o[5] = p6o; assign dut_o[6] = p7o;

   task automatic chk(input string nm, input logic [142:0] act, input logic [142:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic bit lat_ok(input logic [3:0] lat);
      return (lat >= 4'd1) && (lat <= 4'd7);
   endfunction

   function automatic ent_t mk_ent(input iss_t i);
      ent_t r;
      r = '0;
      if (i.v) begin
         r.res = i.res; r.uid = i.uid; r.dst = i.dst; r.lat = i.lat;
         r.wr  = i.wr && lat_ok(i.lat);
      end
      return r;
   endfunction

   function automatic iss_t mk_iss(input logic v, input logic [127:0] res, input logic [2:0] uid,
                                   input logic [6:0] dst, input logic [3:0] lat, input logic wr);
      iss_t r;
      r.v = v; r.res = res; r.uid = uid; r.dst = dst; r.lat = lat; r.wr = wr;
      return r;
   endfunction

   function automatic iss_t rand_iss();
      iss_t r;
      r.v   = ($urandom_range(0, 3) != 0);
      r.res = {$urandom, $urandom, $urandom, $urandom};
      r.uid = 3'($urandom_range(0, 7));
      r.dst = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 7)) : 7'($urandom_range(0, 127));
      r.lat = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 7))
                                         : (($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(8, 15)));
      r.wr  = ($urandom_range(0, 4) != 0);
      return r;
   endfunction

   task automatic model_reset();
      me.delete(); mo.delete();
      for (int i = 0; i < 7; i++) begin
         me.push_back('0); mo.push_back('0);
      end
      m_err = 1'b0;
   endtask

   task automatic model_wb(output bit ee, output bit eo, output bit cf);
      ee = me[6].wr && !me[6].written;
      eo = mo[6].wr && !mo[6].written;
      cf = ee && eo && (me[6].dst == mo[6].dst);
      if (cf) ee = 1'b0;
   endtask

   task automatic clear_wr(input int i);
      ent_t t;
      t = me[i]; t.wr = 1'b0; me[i] = t;
      t = mo[i]; t.wr = 1'b0; mo[i] = t;
   endtask

   task automatic model_commit(input iss_t e, input iss_t o, input bit st, input bit fl);
      ent_t t;
      exp_t x;
      bit ee, eo, cf;
      if (!st && !fl) begin
         if ((e.v && e.wr && !lat_ok(e.lat)) || (o.v && o.wr && !lat_ok(o.lat))) m_err = 1'b1;
      end
      if (st) begin
         t = me[6]; t.written = 1'b1; me[6] = t;
         t = mo[6]; t.written = 1'b1; mo[6] = t;
         if (fl) for (int i = 0; i < FD; i++) clear_wr(i);
      end else begin
         void'(me.pop_back()); void'(mo.pop_back());
         if (fl) begin
            me.push_front('0); mo.push_front('0);
            for (int i = 1; i < FD; i++) clear_wr(i);
         end else begin
            me.push_front(mk_ent(e)); mo.push_front(mk_ent(o));
         end
      end
      model_wb(ee, eo, cf);
      if (ee || eo) begin
         x.ee = ee; x.eo = eo; x.cf = cf;
         x.ae = me[6].dst; x.ao = mo[6].dst; x.de = me[6].res; x.dob = mo[6].res;
         exp_q.push_back(x);
      end
   endtask

   task automatic check_state();
      bit ee, eo, cf;
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("stage%0d_even", k + 1), dut_e[k], me[k][143:1]);
         chk($sformatf("stage%0d_odd", k + 1), dut_o[k], mo[k][143:1]);
      end
      model_wb(ee, eo, cf);
      chk("latency_error", latency_error, m_err);
      chk("wb_en_even", wb_en_even, ee);
      chk("wb_en_odd", wb_en_odd, eo);
      chk("wb_conflict", wb_conflict, cf);
   endtask

   task automatic drive(input iss_t e, input iss_t o, input bit st, input bit fl);
      stall = st; flush = fl;
      ev_v = e.v; ev_res = e.res; ev_uid = e.uid; ev_dst = e.dst; ev_lat = e.lat; ev_wr = e.wr;
      od_v = o.v; od_res = o.res; od_uid = o.uid; od_dst = o.dst; od_lat = o.lat; od_wr = o.wr;
   endtask

   task automatic run_cycle(input iss_t e, input iss_t o, input bit st, input bit fl);
      drive(e, o, st, fl);
      @(negedge clk);
      check_state();
      @(posedge clk);
      model_commit(e, o, st, fl);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      drive(rand_iss(), rand_iss(), 1'b0, 1'b0);
      model_reset();
      exp_q.delete();
      repeat (n) begin
         @(negedge clk);
         check_state();
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
   endtask

   // Scoreboard monitor: every presented write-back is matched against the oldest expectation.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (!reset && (wb_en_even || wb_en_odd || wb_conflict)) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_wb", {wb_en_even, wb_en_odd, wb_conflict}, 3'b000);
            end else begin
               x = exp_q.pop_front();
               chk("sb_en_even", wb_en_even, x.ee);
               chk("sb_en_odd", wb_en_odd, x.eo);
               chk("sb_conflict", wb_conflict, x.cf);
               if (x.ee) begin
                  chk("sb_addr_even", wb_addr_even, x.ae);
                  chk("sb_data_even", wb_data_even, x.de);
               end
               if (x.eo) begin
                  chk("sb_addr_odd", wb_addr_odd, x.ao);
                  chk("sb_data_odd", wb_data_odd, x.dob);
               end
            end
         end
      end
   end

   initial begin
      logic [127:0] aa;
      iss_t e, o;
      bit st, fl;
      idle = '0;
      aa = {4{32'hAAAA_AAAA}};
      do_reset(3);

      run_cycle(mk_iss(1'b1, aa, 3'd1, 7'd5, 4'd2, 1'b1), idle, 1'b0, 1'b0);
      repeat (9) run_cycle(idle, idle, 1'b0, 1'b0);

      run_cycle(mk_iss(1'b1, ~aa, 3'd2, 7'd12, 4'd3, 1'b1), idle, 1'b0, 1'b0);
      repeat (2) run_cycle(idle, idle, 1'b0, 1'b0);
      repeat (3) run_cycle(idle, idle, 1'b1, 1'b0);
      repeat (4) run_cycle(idle, idle, 1'b0, 1'b0);
      repeat (3) run_cycle(idle, idle, 1'b1, 1'b0);
      repeat (3) run_cycle(idle, idle, 1'b0, 1'b0);

      for (int i = 0; i < 5; i++)
         run_cycle(mk_iss(1'b1, {4{$urandom}}, 3'd0, 7'(20 + i), 4'd4, 1'b1),
                   mk_iss(1'b1, {4{$urandom}}, 3'd3, 7'(40 + i), 4'd5, 1'b1), 1'b0, 1'b0);
      run_cycle(idle, idle, 1'b0, 1'b1);
      repeat (8) run_cycle(idle, idle, 1'b0, 1'b0);

      run_cycle(mk_iss(1'b1, aa, 3'd4, 7'd9, 4'd6, 1'b1),
                mk_iss(1'b1, ~aa, 3'd5, 7'd9, 4'd6, 1'b1), 1'b0, 1'b0);
      repeat (8) run_cycle(idle, idle, 1'b0, 1'b0);

      run_cycle(mk_iss(1'b1, aa, 3'd1, 7'd33, 4'd0, 1'b1), idle, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         run_cycle(mk_iss(1'b1, {4{$urandom}}, 3'd1, 7'(50 + i), 4'd7, 1'b1), idle, 1'b0, 1'b0);
      repeat (8) run_cycle(idle, idle, 1'b0, 1'b0);

      for (int phase = 0; phase < 2; phase++) begin
         repeat (phase == 0 ? 1500 : 300) begin
            e  = rand_iss();
            o  = rand_iss();
            st = ($urandom_range(0, 9) < 2);
            fl = ($urandom_range(0, 11) == 0);
            if (fl) begin
               e.v = 1'b0;
               o.v = 1'b0;
            end
            run_cycle(e, o, st, fl);
         end
         repeat (10) run_cycle(idle, idle, 1'b0, 1'b0);
         @(negedge clk);
         chk("sb_drain", 143'(exp_q.size()), 143'd0);
         @(posedge clk);
         #1;
         if (phase == 0) do_reset(2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
